// File: rtl/uart_pkg.sv
// Shared types and constants for the multi-format UART receiver.
package uart_pkg;

    // Default number of oversample ticks per bit period.
    localparam int OVER_SAMPLE_DEF = 16;

    // Receiver frame states.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

    // Runtime parity selection; 2'b11 behaves like PAR_NONE.
    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_e;

    // 2-of-3 majority used for mid-bit noise rejection.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser and 3-tap majority vote around the bit centre.
// v is only meaningful on the tick where cnt == OVER_SAMPLE/2; it combines
// the two captured taps with the live synchronised line.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVER_SAMPLE = OVER_SAMPLE_DEF,
    parameter int CW          = $clog2(OVER_SAMPLE)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_stick,
    input  logic          i_rx_serial,
    input  logic [CW-1:0] cnt,
    output logic          rxs,
    output logic          v
);

    localparam logic [CW-1:0] TAP0 = CW'(OVER_SAMPLE / 2 - 2);
    localparam logic [CW-1:0] TAP1 = CW'(OVER_SAMPLE / 2 - 1);

    logic sync1, sync2;
    logic tap0, tap1;

    // Two-flop synchroniser for the asynchronous serial line, idling high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= i_rx_serial;
            sync2 <= sync1;
        end
    end

    // Capture the two early vote taps just before the bit centre.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tap0 <= 1'b1;
            tap1 <= 1'b1;
        end else if (i_stick) begin
            if (cnt == TAP0) tap0 <= sync2;
            if (cnt == TAP1) tap1 <= sync2;
        end
    end

    assign rxs = sync2;
    assign v   = maj3(tap0, tap1, sync2);

endmodule

// File: rtl/uart_rx_multi.sv
// Parametrised UART receiver: SIZE_DATA data bits, optional parity,
// one or two stop bits, framing/break/overrun reporting.
// Output handshake: o_rx_valid is a single-cycle strobe with no ready;
// o_rx_data and all flags are meaningful only while it is high, flags read
// zero otherwise, and o_rx_data holds the last word between strobes.
// The internal 'state' signal is the observation point for the frame FSM.
module uart_rx_multi
    import uart_pkg::*;
#(
    parameter int SIZE_DATA   = 8,
    parameter int OVER_SAMPLE = OVER_SAMPLE_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_stick,
    input  logic                 i_rx_en,
    input  logic                 i_fifo_full,
    input  logic                 i_rx_serial,
    input  logic [1:0]           i_parity_mode,
    input  logic                 i_stop2,
    output logic [SIZE_DATA-1:0] o_rx_data,
    output logic                 o_rx_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_break,
    output logic                 o_overrun
);

    localparam int CNT_W = $clog2(OVER_SAMPLE);
    localparam int IDX_W = $clog2(SIZE_DATA + 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVER_SAMPLE / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVER_SAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SIZE_DATA - 1);

    rx_state_e            state, state_next;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [SIZE_DATA-1:0] data;
    logic [1:0]           par_l;
    logic                 stop2_l;
    logic                 perr, ferr;
    logic                 rxs, v;
    logic                 tick_mid, tick_end, start_ok, par_en;
    logic                 final_stop, ferr_final, is_break, complete;

    uart_rx_sampler #(
        .OVER_SAMPLE(OVER_SAMPLE),
        .CW         (CNT_W)
    ) u_sampler (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_stick    (i_stick),
        .i_rx_serial(i_rx_serial),
        .cnt        (cnt),
        .rxs        (rxs),
        .v          (v)
    );

    assign tick_mid   = i_stick && (cnt == CNT_MID);
    assign tick_end   = i_stick && (cnt == CNT_LAST);
    assign start_ok   = i_stick && !rxs && i_rx_en && !i_fifo_full;
    assign par_en     = (par_l == PAR_EVEN) || (par_l == PAR_ODD);
    assign final_stop = !stop2_l || (idx == IDX_W'(1));
    assign ferr_final = ferr || !v;
    assign is_break   = (data == '0) && ferr_final;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state decode; completion fires at the centre of the final stop bit
    // so a start edge immediately after the stop bit is not missed.
    always_comb begin
        state_next = state;
        complete   = 1'b0;
        case (state)
            IDLE:   if (start_ok) state_next = START;
            START: begin
                if (tick_mid && v)  state_next = IDLE;
                else if (tick_end)  state_next = DATA;
            end
            DATA:   if (tick_end && idx == IDX_LAST) state_next = par_en ? PARITY : STOP;
            PARITY: if (tick_end) state_next = STOP;
            STOP: begin
                if (tick_mid && final_stop) begin
                    complete   = 1'b1;
                    state_next = (is_break && !rxs) ? BREAK : IDLE;
                end
            end
            BREAK:  if (i_stick && rxs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bit timing, bit index, shift register, config latch and error accumulators.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt     <= '0;
            idx     <= '0;
            data    <= '0;
            par_l   <= PAR_NONE;
            stop2_l <= 1'b0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            if (state_next == IDLE) cnt <= '0;
            else if (i_stick)       cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;

            if (state_next == IDLE)              idx <= '0;
            else if (tick_end && state == DATA)  idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            else if (tick_end && state == STOP)  idx <= idx + 1'b1;

            if (state == IDLE && state_next == START) begin
                par_l   <= i_parity_mode;
                stop2_l <= i_stop2;
                perr    <= 1'b0;
                ferr    <= 1'b0;
            end

            // LSB arrives first, so shifting in from the top leaves it at bit 0.
            if (state == DATA && tick_mid)   data <= {v, data[SIZE_DATA-1:1]};
            if (state == PARITY && tick_mid) perr <= (par_l == PAR_ODD) ? ~(^data ^ v) : (^data ^ v);
            if (state == STOP && tick_mid)   ferr <= ferr_final;
        end
    end

    // Registered result strobe; flags are gated so they read zero between frames.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rx_data    <= '0;
            o_rx_valid   <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_rx_valid   <= complete;
            o_parity_err <= complete & perr;
            o_frame_err  <= complete & ferr_final;
            o_break      <= complete & is_break;
            o_overrun    <= complete & i_fifo_full;
            if (complete) o_rx_data <= data;
        end
    end

endmodule

// File: tb/tb_uart_rx_multi.sv
// Directed bench for uart_rx_multi: an 8-bit/16x instance and a 7-bit/8x instance.
module tb_uart_rx_multi;

    // ---------------- clock / tick / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] div   = 2'd0;
    logic       stick = 1'b0;
    // One oversample tick every four clocks, changed away from the active edge.
    always @(negedge clk) begin
        div   = div + 2'd1;
        stick = (div == 2'd0);
    end

    logic       rst0_n, en0, full0, rx0, stop2_0;
    logic [1:0] par0;
    logic [7:0] data0;
    logic       valid0, perr0, ferr0, brk0, ovr0;

    logic       rst1_n, en1, full1, rx1, stop2_1;
    logic [1:0] par1;
    logic [6:0] data1;
    logic       valid1, perr1, ferr1, brk1, ovr1;

    uart_rx_multi #(.SIZE_DATA(8), .OVER_SAMPLE(16)) dut0 (
        .i_clk(clk), .i_rst_n(rst0_n), .i_stick(stick), .i_rx_en(en0),
        .i_fifo_full(full0), .i_rx_serial(rx0), .i_parity_mode(par0), .i_stop2(stop2_0),
        .o_rx_data(data0), .o_rx_valid(valid0), .o_parity_err(perr0),
        .o_frame_err(ferr0), .o_break(brk0), .o_overrun(ovr0)
    );

    uart_rx_multi #(.SIZE_DATA(7), .OVER_SAMPLE(8)) dut1 (
        .i_clk(clk), .i_rst_n(rst1_n), .i_stick(stick), .i_rx_en(en1),
        .i_fifo_full(full1), .i_rx_serial(rx1), .i_parity_mode(par1), .i_stop2(stop2_1),
        .o_rx_data(data1), .o_rx_valid(valid1), .o_parity_err(perr1),
        .o_frame_err(ferr1), .o_break(brk1), .o_overrun(ovr1)
    );

    // ---------------- capture of completed frames ----------------
    // record = {perr, ferr, break, overrun, data[7:0]}
    typedef logic [11:0] rec_t;
    rec_t got0[$];
    rec_t got1[$];
    int   total = 0;
    int   bad   = 0;

    always @(negedge clk) if (valid0 === 1'b1) got0.push_back({perr0, ferr0, brk0, ovr0, data0});
    always @(negedge clk) if (valid1 === 1'b1) got1.push_back({perr1, ferr1, brk1, ovr1, 1'b0, data1});

    // ---------------- driver tasks ----------------
    task automatic wait_tick();
        do @(posedge clk); while (stick !== 1'b1);
        #1;
    endtask

    task automatic drive(input int which, input logic val, input int ticks);
        if (which == 0) rx0 = val;
        else            rx1 = val;
        repeat (ticks) wait_tick();
    endtask

    task automatic send_frame(input int which, input logic [8:0] d, input int nbits, input int tpb,
                              input bit par_en, input logic par_bit, input logic [1:0] stops,
                              input int nstops, input bit full_mid);
        drive(which, 1'b0, tpb);
        if (full_mid) full0 = 1'b1;
        for (int i = 0; i < nbits; i++) drive(which, d[i], tpb);
        if (par_en) drive(which, par_bit, tpb);
        for (int i = 0; i < nstops; i++) drive(which, stops[i], tpb);
        full0 = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst0_n = 1'b0; rst1_n = 1'b0;
        rx0 = 1'b1; rx1 = 1'b1; en0 = 1'b1; en1 = 1'b1; full0 = 1'b0; full1 = 1'b0;
        par0 = 2'b00; par1 = 2'b00; stop2_0 = 1'b0; stop2_1 = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if ({data0, valid0, perr0, ferr0, brk0, ovr0} !== 13'h0) begin
            bad++; $display("FAIL reset_dut0 got=%h exp=0", {data0, valid0, perr0, ferr0, brk0, ovr0});
        end
        total++;
        if ({data1, valid1, perr1, ferr1, brk1, ovr1} !== 12'h0) begin
            bad++; $display("FAIL reset_dut1 got=%h exp=0", {data1, valid1, perr1, ferr1, brk1, ovr1});
        end
        rst0_n = 1'b1; rst1_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_8n1();
        rec_t r;
        par0 = 2'b00; stop2_0 = 1'b0;
        drive(0, 1'b1, 4);
        send_frame(0, 9'h055, 8, 16, 1'b0, 1'b0, 2'b11, 1, 1'b0);
        drive(0, 1'b1, 8);
        total++; if (got0.size() != 1) begin bad++; $display("FAIL 8n1_count got=%0d exp=1", got0.size()); end
        r = (got0.size() > 0) ? got0.pop_front() : '1;
        total++; if (r[7:0] !== 8'h55) begin bad++; $display("FAIL 8n1_data got=%h exp=55", r[7:0]); end
        total++; if (r[11:8] !== 4'b0000) begin bad++; $display("FAIL 8n1_flags got=%b exp=0000", r[11:8]); end
    endtask

    task automatic test_parity();
        rec_t r;
        par0 = 2'b01; stop2_0 = 1'b0;
        // 0xA3 has four ones: even parity bit should be 0, so 1 is an error.
        drive(0, 1'b1, 4);
        send_frame(0, 9'h0A3, 8, 16, 1'b1, 1'b1, 2'b11, 1, 1'b0);
        drive(0, 1'b1, 4);
        send_frame(0, 9'h0A3, 8, 16, 1'b1, 1'b0, 2'b11, 1, 1'b0);
        drive(0, 1'b1, 8);
        total++; if (got0.size() != 2) begin bad++; $display("FAIL par_count got=%0d exp=2", got0.size()); end
        r = (got0.size() > 0) ? got0.pop_front() : '1;
        total++; if (r !== {4'b1000, 8'hA3}) begin bad++; $display("FAIL par_bad_bit got=%h exp=%h", r, {4'b1000, 8'hA3}); end
        r = (got0.size() > 0) ? got0.pop_front() : '1;
        total++; if (r !== {4'b0000, 8'hA3}) begin bad++; $display("FAIL par_good_bit got=%h exp=%h", r, {4'b0000, 8'hA3}); end
        par0 = 2'b00;
    endtask

    task automatic test_glitch();
        rec_t r;
        drive(0, 1'b1, 4);
        drive(0, 1'b0, 3);
        total++; if (dut0.state !== uart_pkg::START) begin bad++; $display("FAIL glitch_enter got=%0d exp=%0d", dut0.state, uart_pkg::START); end
        drive(0, 1'b1, 20);
        total++; if (dut0.state !== uart_pkg::IDLE) begin bad++; $display("FAIL glitch_exit got=%0d exp=%0d", dut0.state, uart_pkg::IDLE); end
        total++; if (got0.size() != 0) begin bad++; $display("FAIL glitch_novalid got=%0d exp=0", got0.size()); end
        send_frame(0, 9'h03C, 8, 16, 1'b0, 1'b0, 2'b11, 1, 1'b0);
        drive(0, 1'b1, 8);
        total++; if (got0.size() != 1) begin bad++; $display("FAIL glitch_follow_count got=%0d exp=1", got0.size()); end
        r = (got0.size() > 0) ? got0.pop_front() : '1;
        total++; if (r !== {4'b0000, 8'h3C}) begin bad++; $display("FAIL glitch_follow got=%h exp=%h", r, {4'b0000, 8'h3C}); end
    endtask

    task automatic test_stop2_break();
        rec_t r;
        stop2_0 = 1'b1;
        // Second stop bit low through its centre: framing error, data intact.
        drive(0, 1'b1, 4);
        send_frame(0, 9'h0C4, 8, 16, 1'b0, 1'b0, 2'b11, 1, 1'b0);
        drive(0, 1'b0, 9);
        drive(0, 1'b1, 16);
        total++; if (got0.size() != 1) begin bad++; $display("FAIL stop2_count got=%0d exp=1", got0.size()); end
        r = (got0.size() > 0) ? got0.pop_front() : '1;
        total++; if (r !== {4'b0100, 8'hC4}) begin bad++; $display("FAIL stop2_ferr got=%h exp=%h", r, {4'b0100, 8'hC4}); end
        // All-zero frame with line held low: break.
        send_frame(0, 9'h000, 8, 16, 1'b0, 1'b0, 2'b00, 2, 1'b0);
        total++; if (got0.size() != 1) begin bad++; $display("FAIL break_count got=%0d exp=1", got0.size()); end
        r = (got0.size() > 0) ? got0.pop_front() : '1;
        total++; if (r !== {4'b0110, 8'h00}) begin bad++; $display("FAIL break_flags got=%h exp=%h", r, {4'b0110, 8'h00}); end
        drive(0, 1'b0, 100);
        total++; if (got0.size() != 0) begin bad++; $display("FAIL break_hold got=%0d exp=0", got0.size()); end
        drive(0, 1'b1, 8);
        send_frame(0, 9'h05A, 8, 16, 1'b0, 1'b0, 2'b11, 2, 1'b0);
        drive(0, 1'b1, 8);
        total++; if (got0.size() != 1) begin bad++; $display("FAIL break_after_count got=%0d exp=1", got0.size()); end
        r = (got0.size() > 0) ? got0.pop_front() : '1;
        total++; if (r !== {4'b0000, 8'h5A}) begin bad++; $display("FAIL break_after got=%h exp=%h", r, {4'b0000, 8'h5A}); end
        stop2_0 = 1'b0;
    endtask

    task automatic test_back_to_back();
        rec_t r;
        par0 = 2'b00; stop2_0 = 1'b0;
        drive(0, 1'b1, 4);
        send_frame(0, 9'h011, 8, 16, 1'b0, 1'b0, 2'b11, 1, 1'b0);
        send_frame(0, 9'h022, 8, 16, 1'b0, 1'b0, 2'b11, 1, 1'b1);
        drive(0, 1'b1, 8);
        total++; if (got0.size() != 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", got0.size()); end
        r = (got0.size() > 0) ? got0.pop_front() : '1;
        total++; if (r !== {4'b0000, 8'h11}) begin bad++; $display("FAIL b2b_first got=%h exp=%h", r, {4'b0000, 8'h11}); end
        r = (got0.size() > 0) ? got0.pop_front() : '1;
        total++; if (r !== {4'b0001, 8'h22}) begin bad++; $display("FAIL b2b_second got=%h exp=%h", r, {4'b0001, 8'h22}); end
    endtask

    task automatic test_reset_mid_frame();
        rec_t r;
        par1 = 2'b10; stop2_1 = 1'b0;
        // 0x15 and 0x7F both have an odd number of ones: odd parity bit is 0.
        drive(1, 1'b1, 4);
        send_frame(1, 9'h015, 7, 8, 1'b1, 1'b0, 2'b11, 1, 1'b0);
        drive(1, 1'b1, 4);
        total++; if (got1.size() != 1) begin bad++; $display("FAIL w7_first_count got=%0d exp=1", got1.size()); end
        r = (got1.size() > 0) ? got1.pop_front() : '1;
        total++; if (r !== {4'b0000, 8'h15}) begin bad++; $display("FAIL w7_first got=%h exp=%h", r, {4'b0000, 8'h15}); end
        drive(1, 1'b0, 8);
        drive(1, 1'b1, 8);
        drive(1, 1'b1, 8);
        drive(1, 1'b1, 3);
        @(negedge clk);
        rst1_n = 1'b0;
        rx1    = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({data1, valid1, perr1, ferr1, brk1, ovr1} !== 12'h0) begin
            bad++; $display("FAIL w7_in_reset got=%h exp=0", {data1, valid1, perr1, ferr1, brk1, ovr1});
        end
        total++; if (dut1.state !== uart_pkg::IDLE) begin bad++; $display("FAIL w7_reset_state got=%0d exp=%0d", dut1.state, uart_pkg::IDLE); end
        rst1_n = 1'b1;
        drive(1, 1'b1, 8);
        total++; if (got1.size() != 0) begin bad++; $display("FAIL w7_aborted got=%0d exp=0", got1.size()); end
        send_frame(1, 9'h07F, 7, 8, 1'b1, 1'b0, 2'b11, 1, 1'b0);
        drive(1, 1'b1, 4);
        total++; if (got1.size() != 1) begin bad++; $display("FAIL w7_resend_count got=%0d exp=1", got1.size()); end
        r = (got1.size() > 0) ? got1.pop_front() : '1;
        total++; if (r !== {4'b0000, 8'h7F}) begin bad++; $display("FAIL w7_resend got=%h exp=%h", r, {4'b0000, 8'h7F}); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_glitch();
        test_stop2_break();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #5_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/uart_rx_multi.md
# uart_rx_multi

Parametrised UART receiver succeeding the fixed 8N1 receiver in the serial front end, ahead of the decoder input FIFO. It adds:
- configurable data width and oversampling;
- runtime parity (none/even/odd) and 1/2 stop bits;
- input synchronisation with 3-tap majority-vote sampling;
- parity, framing, break and overrun reporting.

It consumes the shared baud tick (`i_stick`) and pushes one word per frame.

## Interface
Parameters:
- `SIZE_DATA`, 8: data bits per frame, legal 5..9.
- `OVER_SAMPLE`, 16: ticks per bit, even, ≥8. MID = OVER_SAMPLE/2.

Ports:
- `i_clk`  in  1  system clock; single clock domain.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_stick`  in  1  oversample tick, one `i_clk` cycle wide.
- `i_rx_en`  in  1  receiver enable; gates start detection only.
- `i_fifo_full`  in  1  downstream FIFO full.
- `i_rx_serial`  in  1  raw serial line, idle high, asynchronous.
- `i_parity_mode`  in  2  00 none, 01 even, 10 odd, 11 treated as none.
- `i_stop2`  in  1  0 = one stop bit, 1 = two stop bits.
- `o_rx_data`  out  SIZE_DATA  last received word, LSB = first bit; reset 0.
- `o_rx_valid`  out  1  one-cycle pulse per completed frame; reset 0.
- `o_parity_err`  out  1  qualified by `o_rx_valid`; reset 0.
- `o_frame_err`  out  1  qualified by `o_rx_valid`; reset 0.
- `o_break`  out  1  qualified by `o_rx_valid`; reset 0.
- `o_overrun`  out  1  qualified by `o_rx_valid`; reset 0.

## Operation
Input sampling:
- `i_rx_serial` passes through a 2-flop synchroniser, reset value 1. All logic below uses the synchronised line `rxs`.
- Bit counter `cnt` advances only on `i_stick`. It wraps OVER_SAMPLE-1 → 0.
- Vote taps are `rxs` at `cnt` = MID-2, MID-1 and MID. The vote result `v` is the 2-of-3 majority, decided on the MID tick.

Configuration latch:
- `i_parity_mode` and `i_stop2` are latched on the IDLE→START transition. Changes mid-frame have no effect.

States:
- IDLE: `cnt` = 0, index = 0. Go to START on `i_stick` & `rxs`==0 & `i_rx_en` & ~`i_fifo_full`.
- START: at MID, if `v`==1 (glitch) return to IDLE with no output. Otherwise, at `cnt`==OVER_SAMPLE-1 go to DATA.
- DATA: at MID, shift `v` into `data[index]`. At `cnt`==OVER_SAMPLE-1, increment index. After bit SIZE_DATA-1 ends, go to PARITY if parity is enabled, else go to STOP.
- PARITY: at MID, compute `perr`:
  - even mode: `perr` = ^data ^ `v`;
  - odd mode: `perr` = ~(^data ^ `v`).
  - At end of the bit go to STOP.
- STOP: each stop bit votes at MID. Any `v`==0 sets `ferr`. With `i_stop2`, the first stop bit runs a full period. At MID of the final stop bit the frame completes:
  - if data==0 & `ferr` & `rxs` currently 0, go to BREAK;
  - otherwise go to IDLE.
- BREAK: wait until `rxs`==1 on an `i_stick`, then go to IDLE. No further frames are received meanwhile.

Frame completion:
- Completing at mid-stop, not end-of-stop, lets a back-to-back start edge be caught.
- On completion, register `o_rx_data` = data, `o_rx_valid` = 1, `o_parity_err` = `perr`, and `o_frame_err` = `ferr`.
- `o_break` = data==0 & `ferr`.
- `o_overrun` = `i_fifo_full` in the completion cycle. The word is still presented.
- Flags are zero whenever `o_rx_valid` is 0. `o_rx_data` holds until the next completion.

Other rules:
- `i_rx_en` falling mid-frame does not abort the frame. The current frame completes.
- Reset mid-frame (asynchronous): state → IDLE, counters → 0, all outputs → reset values, synchroniser → 1.
- The next frame's first sample occurs no earlier than the first tick after returning to IDLE.

## Timing
- Start latency is 2 `i_clk` cycles (synchroniser) plus the first qualifying tick.
- `o_rx_valid` asserts on the `i_clk` edge following the tick with `cnt`==MID of the final stop bit.
- Frame length in ticks:
  - START→completion = OVER_SAMPLE·(1 + SIZE_DATA + P + S − 1) + MID + 1 ticks;
  - P = 1 if parity is enabled, else 0;
  - S = 1 + `i_stop2`.
- No backpressure: `o_rx_valid` is never stalled. The consumer must accept it or observe `o_overrun`.
- `i_stick` asserted on consecutive cycles is legal. Each assertion counts one tick.

## Structure
- Package `uart_pkg`:
  - state enum `rx_state_e` {IDLE, START, DATA, PARITY, STOP, BREAK};
  - parity enum `parity_e` {PAR_NONE = 2'b00, PAR_EVEN = 2'b01, PAR_ODD = 2'b10};
  - shared OVER_SAMPLE default constant.
- Sub-module `uart_rx_sampler`: synchroniser plus 3-tap majority vote. Inputs are `i_clk`, `i_rst_n`, `i_stick`, `i_rx_serial` and `cnt`. Outputs are `rxs` and `v`.
- Counter width is $clog2(OVER_SAMPLE). Index width is $clog2(SIZE_DATA+1).

## Test plan
- 8N1, send 0x55 with an exact 16-tick bit period → one `o_rx_valid` pulse, `o_rx_data`=0x55, all flags 0.
- Even parity, send 0xA3 with parity bit 1 (wrong; correct is 0) → `o_rx_data`=0xA3, `o_parity_err`=1; resend with parity bit 0 → `o_parity_err`=0.
- Line low for 3 ticks in IDLE (glitch) → START entered then exits at MID; no `o_rx_valid`; a following 0x3C frame is received correctly.
- `i_stop2`=1 with the second stop bit driven 0 → `o_frame_err`=1, data intact; with 0x00 data and the line held low → `o_break`=1; no further valid until the line returns high.
- Back-to-back 0x11 then 0x22 with zero idle gap → two valids, in order, both error-free; `i_fifo_full` raised during the second frame → second valid has `o_overrun`=1.
- SIZE_DATA=7, OVER_SAMPLE=8, odd parity, 0x7F; assert `i_rst_n`=0 during DATA, release, resend → outputs 0 during reset; clean 0x7F with no errors after.
